spike_decoder: RTL and testbench

SPIKE_DECODER -- requirements
Module: spike_decoder

---
 rtl/spike_decoder.sv | 78 +++++++
 tb/tb_spike_decoder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/spike_decoder.sv
// spike_decoder: decaying post-synaptic current integrator plus windowed spike-rate counter
module spike_decoder #(
  parameter int WINDOW      = 16,
  parameter int DECAY_SHIFT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       spike_in,
  input  logic [7:0] weight,
  output logic [7:0] current,
  output logic [7:0] rate,
  output logic       rate_valid
);
  localparam int IW = $clog2(WINDOW);
  localparam logic [IW-1:0] LAST = IW'(WINDOW - 1);
  typedef enum logic {IDLE, COUNT} state_t;
  state_t        state_q, state_d;
  logic [7:0]    cur_q, cur_d, cnt_q, cnt_d, rate_q, rate_d, shifted, dec, cnt_inc;
  logic [8:0]    cur_sum;
  logic [IW-1:0] idx_q, idx_d;
  logic          rv_q, rv_d;
  // current leaks by a shifted fraction (at least 1 while nonzero) and adds the weight of an arriving spike
  always_comb begin
    shifted = cur_q >> DECAY_SHIFT;
    dec     = (shifted == 8'd0 && cur_q != 8'd0) ? 8'd1 : shifted;
    cur_sum = {1'b0, cur_q} - {1'b0, dec} + {1'b0, spike_in ? weight : 8'd0};
    cur_d   = !en ? cur_q : cur_sum[8] ? 8'hFF : cur_sum[7:0];
  end
  // window FSM: a spike opens a window, the last window cycle publishes the count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rate_d  = rate_q;
    rv_d    = 1'b0;
    cnt_inc = (spike_in && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    if (en) begin
      if (state_q == IDLE) begin
        if (spike_in) begin
          state_d = COUNT;
          cnt_d   = 8'd1;
          idx_d   = IW'(1);
        end
      end else if (idx_q == LAST) begin
        rate_d  = cnt_inc;
        rv_d    = 1'b1;
        cnt_d   = 8'd0;
        idx_d   = '0;
        state_d = (cnt_inc != 8'd0) ? COUNT : IDLE;
      end else begin
        cnt_d = cnt_inc;
        idx_d = idx_q + 1'b1;
      end
    end
  end
  // state registers with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= 8'd0;
      cnt_q   <= 8'd0;
      idx_q   <= '0;
      rate_q  <= 8'd0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rate_q  <= rate_d;
      rv_q    <= rv_d;
    end
  end
  assign current    = cur_q;
  assign rate       = rate_q;
  assign rate_valid = rv_q;
endmodule

// File: tb/tb_spike_decoder.sv
// tb_spike_decoder: vector table, corner sequences and randomized run against a behavioural model
module tb_spike_decoder;
  localparam int WIN = 16;
  localparam int DS  = 2;
  logic       clk = 1'b0;
  logic       rst = 1'b0, en = 1'b0, spike_in = 1'b0;
  logic [7:0] weight = 8'd0;
  logic [7:0] current, rate;
  logic       rate_valid;
  int tests = 0, fails = 0;
  int m_cur = 0, m_rate = 0, m_rv = 0, ecnt = 0, wstart = 0, spikes = 0;
  bit active = 0;
  typedef struct {
    logic       r, e, s;
    logic [7:0] w, cur, rt;
    logic       v;
  } vec_t;
  vec_t tbl[$];
  int seq[16] = '{64, 48, 36, 27, 21, 16, 12, 9, 7, 6, 5, 4, 3, 2, 1, 0};

  spike_decoder #(.WINDOW(WIN), .DECAY_SHIFT(DS)) dut (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in), .weight(weight),
    .current(current), .rate(rate), .rate_valid(rate_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model works in enabled-cycle numbers: a window spans WIN enabled cycles from its start
  task automatic model(input bit r, input bit e, input bit s, input int w);
    int dec, nxt;
    if (r) begin
      m_cur = 0; m_rate = 0; m_rv = 0; active = 0; spikes = 0;
    end else if (!e) begin
      m_rv = 0;
    end else begin
      dec = m_cur / (1 << DS);
      if (m_cur != 0 && dec == 0) dec = 1;
      nxt = m_cur - dec + (s ? w : 0);
      m_cur = nxt > 255 ? 255 : nxt;
      m_rv = 0;
      ecnt++;
      if (!active) begin
        if (s) begin active = 1; wstart = ecnt; spikes = 1; end
      end else begin
        if (s && spikes < 255) spikes++;
        if (ecnt - wstart == WIN - 1) begin
          m_rate = spikes; m_rv = 1;
          active = (spikes != 0);
          wstart = ecnt + 1;
          spikes = 0;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input bit s, input int w);
    rst = r; en = e; spike_in = s; weight = 8'(w);
    @(posedge clk);
    model(r, e, s, w);
    #1;
    check("model_current", int'(current), m_cur);
    check("model_rate", int'(rate), m_rate);
    check("model_rate_valid", int'(rate_valid), m_rv);
  endtask

  task automatic add(input logic r, e, s, input logic [7:0] w, c, rt, input logic v);
    tbl.push_back('{r, e, s, w, c, rt, v});
  endtask

  initial begin
    logic [7:0] sc, sr;
    add(1, 1, 1, 8'hFF, 0, 0, 0);
    add(1, 1, 0, 8'hFF, 0, 0, 0);
    add(1, 0, 1, 8'hFF, 0, 0, 0);
    add(0, 1, 1, 8'h40, 8'(seq[0]), 0, 0);
    for (int j = 1; j < 16; j++) add(0, 1, 0, 8'h40, 8'(seq[j]), (j == 15) ? 8'd1 : 8'd0, j == 15);
    for (int j = 16; j < 32; j++) add(0, 1, 0, 8'h00, 0, (j == 31) ? 8'd0 : 8'd1, j == 31);
    add(0, 1, 0, 8'h00, 0, 0, 0);
    add(0, 1, 0, 8'h00, 0, 0, 0);
    @(negedge clk);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].e, tbl[i].s, int'(tbl[i].w));
      check("vec_current", int'(current), int'(tbl[i].cur));
      check("vec_rate", int'(rate), int'(tbl[i].rt));
      check("vec_rate_valid", int'(rate_valid), int'(tbl[i].v));
    end
    // spikes on first and last window cycles both land in the same window
    step(0, 1, 1, 10);
    for (int i = 1; i < 15; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 10);
    check("edge_rate", int'(rate), 2);
    check("edge_rate_valid", int'(rate_valid), 1);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0);
    check("empty_rate", int'(rate), 0);
    check("empty_rate_valid", int'(rate_valid), 1);
    step(0, 1, 0, 0);
    // stall mid-window: outputs freeze and stalled spikes are not counted
    for (int i = 0; i < 4; i++) step(0, 1, 1, 20);
    sc = current; sr = rate;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 200);
      check("stall_current", int'(current), int'(sc));
      check("stall_rate", int'(rate), int'(sr));
      check("stall_rate_valid", int'(rate_valid), 0);
    end
    for (int i = 4; i < 15; i++) begin
      step(0, 1, 0, 0);
      check("stall_no_early_valid", int'(rate_valid), 0);
    end
    step(0, 1, 0, 0);
    check("stall_rate_end", int'(rate), 4);
    check("stall_rate_valid_end", int'(rate_valid), 1);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0);
    // reset at window cycle 7 discards the partial window
    for (int i = 0; i < 3; i++) step(0, 1, 1, 30);
    for (int i = 3; i < 7; i++) step(0, 1, 0, 0);
    step(1, 1, 1, 30);
    check("rst_current", int'(current), 0);
    check("rst_rate", int'(rate), 0);
    check("rst_rate_valid", int'(rate_valid), 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 0);
      check("rst_no_valid", int'(rate_valid), 0);
    end
    // continuous full-weight spikes saturate the current and fill every window
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 1, 255);
      check("sat_current", int'(current), 255);
      if (i == 15 || i == 31) begin
        check("sat_rate", int'(rate), 16);
        check("sat_rate_valid", int'(rate_valid), 1);
      end
    end
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 9) < 3, int'($urandom_range(0, 255)));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
